// File: rtl/dfi_init_pkg.sv
// Shared types and constants for the DFI init / frequency-change sequencer.
package dfi_init_pkg;

    localparam int DFI_FREQ_W = 5;

    typedef enum logic [2:0] {
        BOOT,
        READY,
        DROP,
        WAIT_FW,
        DONE
    } dfi_init_state_e;

    function automatic logic is_busy(dfi_init_state_e s);
        return (s == DROP) || (s == WAIT_FW) || (s == DONE);
    endfunction

endpackage

// File: rtl/dfi_init_timer.sv
// Up-counter with synchronous load-to-zero, enable and saturation at all-ones.
// hit_o flags count == limit_i.
module dfi_init_timer #(
    parameter int CntW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            en_i,
    input  logic [CntW-1:0] limit_i,
    output logic            hit_o
);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == limit_i);

endmodule

// File: rtl/dfi_init_seq.sv
// DFI init / frequency-change handshake sequencer between the memory controller
// and dfi_gpio firmware bits, with timeout and sticky protocol-error flags.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   BOOT    | after reset, waiting for firmware power-up training done
//   READY   | complete high, waiting for a controller start rise
//   DROP    | complete held low for MinCompleteLow cycles
//   WAIT_FW | waiting for a fresh firmware done rise or the timeout
//   DONE    | complete high, waiting for the controller to drop start
module dfi_init_seq
    import dfi_init_pkg::*;
#(
    parameter int MinCompleteLow = 4,
    parameter int TimeoutCycles  = 65535,
    parameter int FreqW          = DFI_FREQ_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             dfi_init_start_i,
    input  logic [FreqW-1:0] dfi_frequency_i,
    output logic             dfi_init_complete_o,
    output logic             gpio_init_start_o,
    input  logic             gpio_init_done_i,
    output logic [FreqW-1:0] freq_o,
    output logic             busy_o,
    output logic             timeout_o,
    output logic             proto_err_o,
    input  logic             clr_err_i
);

    localparam int CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] MinLim = CntW'(MinCompleteLow - 1);
    localparam logic [CntW-1:0] ToLim  = CntW'(TimeoutCycles - 1);

    dfi_init_state_e  state_q, state_d;
    logic             start_q, done_q;
    logic             done_seen_q, done_seen_d;
    logic             complete_q, complete_d;
    logic             gpio_start_q, gpio_start_d;
    logic [FreqW-1:0] freq_q, freq_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic             proto_err_q, proto_err_d;

    logic             start_rise, start_fall, done_rise;
    logic             accept, in_run, fw_done;
    logic             tmr_en, tmr_hit;
    logic [CntW-1:0]  tmr_limit;

    assign start_rise = dfi_init_start_i & ~start_q;
    assign start_fall = ~dfi_init_start_i & start_q;
    assign done_rise  = gpio_init_done_i & ~done_q;
    assign accept     = (state_q == READY) && start_rise;
    assign in_run     = (state_q == DROP) || (state_q == WAIT_FW);
    assign fw_done    = done_rise | done_seen_q;
    assign tmr_en     = in_run;
    assign tmr_limit  = (state_q == DROP) ? MinLim : ToLim;

    dfi_init_timer #(
        .CntW (CntW)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (accept),
        .en_i    (tmr_en),
        .limit_i (tmr_limit),
        .hit_o   (tmr_hit)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= BOOT;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            done_seen_q  <= 1'b0;
            complete_q   <= 1'b0;
            gpio_start_q <= 1'b0;
            freq_q       <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= dfi_init_start_i;
            done_q       <= gpio_init_done_i;
            done_seen_q  <= done_seen_d;
            complete_q   <= complete_d;
            gpio_start_q <= gpio_start_d;
            freq_q       <= freq_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            proto_err_q  <= proto_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    if (done_rise) state_d = READY;
            READY:   if (start_rise) state_d = DROP;
            DROP:    if (tmr_hit) state_d = WAIT_FW;
            WAIT_FW: if (fw_done || tmr_hit) state_d = DONE;
            DONE:    if (!dfi_init_start_i) state_d = READY;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        complete_d   = (state_d == READY) || (state_d == DONE);
        busy_d       = is_busy(state_d);
        freq_d       = accept ? dfi_frequency_i : freq_q;

        // A done rise during DROP is too early to act on but must not be lost.
        done_seen_d  = done_seen_q;
        if (accept) begin
            done_seen_d = 1'b0;
        end else if ((state_q == DROP) && done_rise) begin
            done_seen_d = 1'b1;
        end

        gpio_start_d = gpio_start_q;
        if (accept) begin
            gpio_start_d = 1'b1;
        end else if (in_run && start_fall) begin
            gpio_start_d = 1'b0;
        end else if ((state_q == DONE) && !dfi_init_start_i) begin
            gpio_start_d = 1'b0;
        end

        // Error flags: a new event in the same cycle as clr_err_i stays set.
        timeout_d = timeout_q & ~clr_err_i;
        if ((state_q == WAIT_FW) && !fw_done && tmr_hit) begin
            timeout_d = 1'b1;
        end

        proto_err_d = proto_err_q & ~clr_err_i;
        if (in_run && start_fall) begin
            proto_err_d = 1'b1;
        end
    end

    assign dfi_init_complete_o = complete_q;
    assign gpio_init_start_o   = gpio_start_q;
    assign freq_o              = freq_q;
    assign busy_o              = busy_q;
    assign timeout_o           = timeout_q;
    assign proto_err_o         = proto_err_q;

endmodule

// File: tb/tb_dfi_init_seq.sv
// Directed self-checking bench for dfi_init_seq (MinCompleteLow=4, TimeoutCycles=16).
module tb_dfi_init_seq;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       start_i;
    logic [4:0] freq_i;
    logic       complete_o;
    logic       gpio_start_o;
    logic       done_i;
    logic [4:0] freq_o;
    logic       busy_o;
    logic       timeout_o;
    logic       proto_err_o;
    logic       clr_err_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    dfi_init_seq #(
        .MinCompleteLow (4),
        .TimeoutCycles  (16),
        .FreqW          (5)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .dfi_init_start_i    (start_i),
        .dfi_frequency_i     (freq_i),
        .dfi_init_complete_o (complete_o),
        .gpio_init_start_o   (gpio_start_o),
        .gpio_init_done_i    (done_i),
        .freq_o              (freq_o),
        .busy_o              (busy_o),
        .timeout_o           (timeout_o),
        .proto_err_o         (proto_err_o),
        .clr_err_i           (clr_err_i)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; start_i = 1'b0; freq_i = 5'h00; done_i = 1'b0; clr_err_i = 1'b0;
        tick(); tick();
        checks++;
        if ({complete_o, gpio_start_o, freq_o, busy_o, timeout_o, proto_err_o} !== 10'b0) begin
            $display("FAIL reset_outputs got %b expected 0",
                     {complete_o, gpio_start_o, freq_o, busy_o, timeout_o, proto_err_o});
            errors++;
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_boot();
        for (int i = 0; i < 3; i++) tick();
        start_i = 1'b1;
        tick();
        checks++;
        if ({complete_o, gpio_start_o, busy_o} !== 3'b000) begin
            $display("FAIL boot_start_ignored got %b expected 000", {complete_o, gpio_start_o, busy_o});
            errors++;
        end
        start_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        done_i = 1'b1;
        checks++;
        if (complete_o !== 1'b0) begin
            $display("FAIL boot_pre_done complete got %b expected 0", complete_o);
            errors++;
        end
        tick();
        checks++;
        if ({complete_o, busy_o} !== 2'b10) begin
            $display("FAIL boot_done complete/busy got %b expected 10", {complete_o, busy_o});
            errors++;
        end
    endtask

    task automatic test_freq_change();
        start_i = 1'b1; freq_i = 5'h03; done_i = 1'b0;
        tick();
        checks++;
        if ({complete_o, gpio_start_o, busy_o, freq_o} !== {3'b011, 5'h03}) begin
            $display("FAIL freq_accept c/g/b/freq got %b expected 011_00011",
                     {complete_o, gpio_start_o, busy_o, freq_o});
            errors++;
        end
        tick();
        done_i = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            tick();
            checks++;
            if (complete_o !== 1'b0) begin
                $display("FAIL freq_min_low cycle %0d complete got %b expected 0", i, complete_o);
                errors++;
            end
        end
        tick();
        checks++;
        if ({complete_o, gpio_start_o, busy_o} !== 3'b111) begin
            $display("FAIL freq_done c/g/b got %b expected 111", {complete_o, gpio_start_o, busy_o});
            errors++;
        end
        start_i = 1'b0;
        tick();
        checks++;
        if ({complete_o, gpio_start_o, busy_o, proto_err_o, freq_o} !== {4'b1000, 5'h03}) begin
            $display("FAIL freq_ready c/g/b/p/freq got %b expected 1000_00011",
                     {complete_o, gpio_start_o, busy_o, proto_err_o, freq_o});
            errors++;
        end
    endtask

    task automatic test_stale_timeout();
        start_i = 1'b1; freq_i = 5'h0a;
        tick();
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++;
            if ({complete_o, timeout_o} !== 2'b00) begin
                $display("FAIL stale_wait cycle %0d complete/timeout got %b expected 00",
                         i, {complete_o, timeout_o});
                errors++;
            end
        end
        tick();
        checks++;
        if ({complete_o, timeout_o, freq_o} !== {2'b11, 5'h0a}) begin
            $display("FAIL stale_timeout c/t/freq got %b expected 11_01010",
                     {complete_o, timeout_o, freq_o});
            errors++;
        end
        start_i = 1'b0;
        tick();
        checks++;
        if ({gpio_start_o, timeout_o, busy_o} !== 3'b010) begin
            $display("FAIL timeout_sticky g/t/b got %b expected 010", {gpio_start_o, timeout_o, busy_o});
            errors++;
        end
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        checks++;
        if (timeout_o !== 1'b0) begin
            $display("FAIL timeout_clear got %b expected 0", timeout_o);
            errors++;
        end
    endtask

    task automatic test_abort();
        start_i = 1'b1; freq_i = 5'h07; done_i = 1'b0;
        for (int i = 0; i <= 4; i++) tick();
        start_i = 1'b0; clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        checks++;
        if ({proto_err_o, gpio_start_o, complete_o, busy_o} !== 4'b1001) begin
            $display("FAIL abort_flag p/g/c/b got %b expected 1001",
                     {proto_err_o, gpio_start_o, complete_o, busy_o});
            errors++;
        end
        done_i = 1'b1;
        tick();
        checks++;
        if ({complete_o, busy_o} !== 2'b11) begin
            $display("FAIL abort_done c/b got %b expected 11", {complete_o, busy_o});
            errors++;
        end
        tick();
        checks++;
        if ({complete_o, busy_o, proto_err_o} !== 3'b101) begin
            $display("FAIL abort_ready c/b/p got %b expected 101", {complete_o, busy_o, proto_err_o});
            errors++;
        end
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        checks++;
        if (proto_err_o !== 1'b0) begin
            $display("FAIL proto_clear got %b expected 0", proto_err_o);
            errors++;
        end
    endtask

    task automatic test_simultaneous();
        done_i = 1'b0;
        tick();
        start_i = 1'b1; done_i = 1'b1; freq_i = 5'h11;
        tick();
        checks++;
        if ({complete_o, busy_o, gpio_start_o} !== 3'b011) begin
            $display("FAIL simul_accept c/b/g got %b expected 011", {complete_o, busy_o, gpio_start_o});
            errors++;
        end
        for (int i = 1; i <= 8; i++) tick();
        checks++;
        if (complete_o !== 1'b0) begin
            $display("FAIL simul_done_discarded complete got %b expected 0", complete_o);
            errors++;
        end
        done_i = 1'b0;
        tick();
        done_i = 1'b1;
        tick();
        checks++;
        if ({complete_o, timeout_o} !== 2'b10) begin
            $display("FAIL simul_late_done c/t got %b expected 10", {complete_o, timeout_o});
            errors++;
        end
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        start_i = 1'b1; freq_i = 5'h1a; done_i = 1'b0;
        for (int i = 0; i <= 4; i++) tick();
        checks++;
        if ({gpio_start_o, freq_o, complete_o} !== {1'b1, 5'h1a, 1'b0}) begin
            $display("FAIL mid_pre_reset g/freq/c got %b expected 1_11010_0",
                     {gpio_start_o, freq_o, complete_o});
            errors++;
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({complete_o, gpio_start_o, freq_o, busy_o} !== 8'b0) begin
            $display("FAIL mid_async_reset c/g/freq/b got %b expected 0",
                     {complete_o, gpio_start_o, freq_o, busy_o});
            errors++;
        end
        start_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        start_i = 1'b1;
        tick(); tick();
        checks++;
        if ({complete_o, busy_o, gpio_start_o} !== 3'b000) begin
            $display("FAIL mid_back_in_boot c/b/g got %b expected 000", {complete_o, busy_o, gpio_start_o});
            errors++;
        end
        start_i = 1'b0;
        done_i = 1'b1;
        tick();
        checks++;
        if (complete_o !== 1'b1) begin
            $display("FAIL mid_reboot complete got %b expected 1", complete_o);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_freq_change();
        test_stale_timeout();
        test_abort();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
